// File: rtl/uart_pkg.sv
// Shared UART receive-path types and widths.
package uart_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int ERR_CNT_W   = 8;

  typedef struct packed {
    logic                   err;
    logic [UART_BYTE_W-1:0] data;
  } uart_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte handshake between the UART receiver, the receive FIFO and its consumer.
interface uart_rx_fifo_if;
  import uart_pkg::*;

  logic                   wr_valid;
  logic [UART_BYTE_W-1:0] wr_data;
  logic                   wr_error;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [UART_BYTE_W-1:0] rd_data;
  logic                   rd_err;

  modport master (
    output wr_valid, wr_data, wr_error, rd_ready,
    input  rd_valid, rd_data, rd_err
  );

  modport slave (
    input  wr_valid, wr_data, wr_error, rd_ready,
    output rd_valid, rd_data, rd_err
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x {err,data} register array: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [AW-1:0] waddr,
  input  uart_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output uart_entry_t rdata
);

  uart_entry_t mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with level, almost-full, sticky
// overflow and saturating framing-error count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ALMOST_FULL = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  uart_rx_fifo_if.slave          bus,
  input  logic                   ovf_clear,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic                   overflow,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] level_nxt;
  logic          empty, full, push, pop, drop;
  uart_entry_t   wr_entry, rd_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign bus.rd_valid = !empty;
  assign pop  = !empty && bus.rd_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push = bus.wr_valid && (!full || pop);
  assign drop = bus.wr_valid && full && !pop;

  assign wr_entry.err  = bus.wr_error;
  assign wr_entry.data = bus.wr_data;

  assign bus.rd_data = rd_entry.data;
  assign bus.rd_err  = rd_entry.err;

  assign level_nxt = level + PW'(push) - PW'(pop);

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (push),
    .waddr   (wr_ptr[AW-1:0]),
    .wdata   (wr_entry),
    .raddr   (rd_ptr[AW-1:0]),
    .rdata   (rd_entry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level       <= level_nxt;
      almost_full <= (level_nxt >= PW'(ALMOST_FULL));
    end
  end

  // Events take priority over ovf_clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;

      if (push && bus.wr_error) begin
        if (ovf_clear)             err_count <= ERR_CNT_W'(1);
        else if (err_count != '1)  err_count <= err_count + 1'b1;
      end else if (ovf_clear) begin
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk;
  logic       reset_n;
  logic       ovf_clear;
  logic [4:0] level;
  logic       almost_full;
  logic       overflow;
  logic [7:0] err_count;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .DEPTH       (DEPTH),
    .ALMOST_FULL (AF)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .ovf_clear   (ovf_clear),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [8:0] sb [$];
  logic       m_ovf;
  logic [7:0] m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".rd_valid"},    32'(bus.rd_valid), 32'd0);
    chk({tag, ".rd_data"},     32'(bus.rd_data),  32'd0);
    chk({tag, ".rd_err"},      32'(bus.rd_err),   32'd0);
    chk({tag, ".level"},       32'(level),        32'd0);
    chk({tag, ".almost_full"}, 32'(almost_full),  32'd0);
    chk({tag, ".overflow"},    32'(overflow),     32'd0);
    chk({tag, ".err_count"},   32'(err_count),    32'd0);
  endtask

  // Called at posedge+1: drive inputs, check head before the edge, update model,
  // then check registered state after the edge.
  task automatic cyc(input logic wv, input logic [7:0] wd, input logic we,
                     input logic rr, input logic clr);
    logic pop_e, push_e, drop_e;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.wr_error = we;
    bus.rd_ready = rr;
    ovf_clear    = clr;
    #3;
    chk("rd_valid", 32'(bus.rd_valid), 32'(sb.size() != 0));
    pop_e  = (sb.size() != 0) && rr;
    if (pop_e) begin
      chk("rd_data", 32'(bus.rd_data), 32'(sb[0][7:0]));
      chk("rd_err",  32'(bus.rd_err),  32'(sb[0][8]));
      void'(sb.pop_front());
    end
    push_e = wv && ((sb.size() + (pop_e ? 1 : 0)) < DEPTH || pop_e);
    drop_e = wv && !push_e;
    if (push_e) sb.push_back({we, wd});
    if (drop_e)   m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (push_e && we) m_err = clr ? 8'd1 : (m_err == 8'hFF ? m_err : m_err + 8'd1);
    else if (clr)     m_err = 8'd0;
    @(posedge clk);
    #1;
    chk("level",       32'(level),       32'(sb.size()));
    chk("almost_full", 32'(almost_full), 32'(sb.size() >= AF));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("err_count",   32'(err_count),   32'(m_err));
  endtask

  task automatic drain();
    int unsigned guard = 0;
    while (sb.size() != 0 && guard < 4 * DEPTH) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    m_ovf        = 1'b0;
    m_err        = 8'd0;
    reset_n      = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.wr_error = 1'b0;
    bus.rd_ready = 1'b0;
    ovf_clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte latency and pop
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Fill to full, almost_full threshold, ordered drain
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'd16);
    drain();

    // Overflow drop, then push+pop at full
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("full_pushpop_level", 32'(level), 32'd16);
    drain();

    // Error bytes and ovf_clear racing an error push
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 1'b0);
    chk("err3", 32'(err_count), 32'd3);
    drain();
    cyc(1'b1, 8'h44, 1'b1, 1'b0, 1'b1);
    chk("err_clr_race", 32'(err_count), 32'd1);
    chk("ovf_cleared",  32'(overflow),  32'd0);
    drain();

    // Streaming with rd_ready held high
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b1, 1'b0);
      if (i == 20) chk("stream_level", 32'(level), 32'd1);
    end
    drain();
    chk("stream_ovf", 32'(overflow), 32'd0);

    // Error counter saturation
    for (int i = 0; i < 260; i++) cyc(1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
    drain();
    chk("err_sat", 32'(err_count), 32'd255);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset during a push
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h77;
    reset_n      = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    sb.delete();
    m_ovf = 1'b0;
    m_err = 8'd0;
    @(posedge clk);
    #1;
    chk_reset_outputs("reset_held");
    bus.wr_valid = 1'b0;
    reset_n      = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. Captures each completed byte, together with its framing-error status, on the receiver's one-cycle done strobe. Presents bytes to the consumer in arrival order over a first-word-fall-through valid/ready interface. Reports fill level, almost-full, sticky overflow and a saturating framing-error count.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, ≥ 2.
- `ALMOST_FULL`, 12, level at or above which `almost_full` asserts; 1 ≤ value ≤ `DEPTH`.
- `clk` input 1, single clock; all logic on the rising edge.
- `reset_n` input 1, asynchronous, active-low reset.
- `wr_valid` input 1, one-cycle byte-complete strobe from the receiver (its `rx_done`).
- `wr_data` input 8, received byte; sampled only when `wr_valid`=1.
- `wr_error` input 1, framing-error flag for that byte (receiver `rx_error`); sampled with `wr_data`.
- `rd_valid` output 1, head entry present.
- `rd_ready` input 1, consumer accepts head; pop occurs when `rd_valid && rd_ready`.
- `rd_data` output 8, head byte.
- `rd_err` output 1, framing-error flag stored with the head byte.
- `level` output $clog2(DEPTH)+1, current entry count, 0..`DEPTH`.
- `almost_full` output 1, `level >= ALMOST_FULL`.
- `overflow` output 1, sticky; set when a byte is dropped.
- `ovf_clear` input 1, synchronous clear of `overflow` and `err_count`.
- `err_count` output 8, saturating count of accepted bytes with `wr_error`=1.

## Operation
- Storage: `DEPTH` entries of 9 bits {err, data}. Write and read pointers are $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty; pointers wrap modulo 2·`DEPTH`.
- Empty: pointers equal. Full: indices equal and MSBs differ.
- Push: `wr_valid`=1 and (not full, or pop in the same cycle). Write at `wr_ptr`, then increment.
- Pop: `rd_valid && rd_ready`. Increment `rd_ptr`.
- Full with `wr_valid`, no pop: byte dropped, `overflow` ← 1, contents and pointers unchanged.
- Full with `wr_valid` and pop in the same cycle: both occur, `level` stays `DEPTH`, no overflow.
- Empty with `wr_valid`: push only; no pop, since `rd_valid`=0 in that cycle.
- `level` updates as follows: push only +1, pop only −1, both or neither unchanged.
- `err_count` increments on each accepted push with `wr_error`=1 and saturates at 255. Dropped bytes are not counted.
- `ovf_clear` with a simultaneous overflow or error event: the event wins. `overflow` reads 1; `err_count` reads 1 if that push carried an error, otherwise 0.
- `rd_data` and `rd_err` are driven from the storage entry at `rd_ptr`. When `rd_valid`=0 they hold that entry's stale contents; consumers must ignore them.
- Reset mid-operation: contents are discarded immediately, regardless of any strobe in flight.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `rd_err`=0, `level`=0, `almost_full`=0 (any legal `ALMOST_FULL`), `overflow`=0, `err_count`=0. Storage array and pointers reset to 0.
- Write-to-read latency: with `wr_valid` sampled at edge N into an empty FIFO, `rd_valid`=1 and `rd_data` is valid after edge N, i.e. in cycle N+1.
- Pop at edge M: the next entry, or `rd_valid`=0, is presented in cycle M+1.
- Throughput: one push and one pop per cycle sustained.
- `level`, `almost_full` and `overflow` are registered and reflect state after each edge.
- `rd_ready` may be held high continuously. `rd_valid` does not depend combinationally on `rd_ready`.

## Structure
- Shared package `uart_pkg`:
  - `UART_BYTE_W`=8.
  - Entry type {err, data}, 9 bits.
  - `ERR_CNT_W`=8.
- One sub-module, `uart_fifo_mem`: a DEPTH×9 register array with synchronous write and asynchronous read, reset to 0.
- Pointer, flag and counter logic lives in `uart_rx_fifo`.

## Test plan
- Reset, then push 0xA5 (err=0) → `rd_valid`=1 one cycle later, `rd_data`=0xA5, `rd_err`=0, `level`=1. Pop → `level`=0, `rd_valid`=0.
- Push 16 bytes 0x00..0x0F with `rd_ready`=0 → `level`=16. `almost_full` rises at the 12th push. Drain reads 0x00..0x0F in order.
- Fill to 16, push 0xFF with no pop → `overflow`=1, `level`=16, 0xFF never read. Push 0xEE with a simultaneous pop → `level`=16, 0xEE read last.
- Push 3 bytes with `wr_error`=1 → `err_count`=3 and `rd_err`=1 on each. Assert `ovf_clear` in the same cycle as a 4th error push → `err_count`=1.
- `rd_ready`=1 constantly, `wr_valid` every cycle for 40 cycles → `level` never exceeds 1, every byte delivered, `overflow`=0.
- Assert `reset_n` low with `level`=5 during a push → all outputs at reset values immediately; the push is lost.
